// File: rtl/datapath_xyz.sv
// Three-register datapath (X operand, Y accumulator, Z display) with a combinational ALU feeding Y.
// Per-register op codes come from the upstream control decoder; unused codes hold.
module datapath_xyz #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] entrada,
  input  logic [3:0]   Tx,
  input  logic [3:0]   Ty,
  input  logic [3:0]   Tz,
  input  logic [3:0]   Tula,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] z,
  output logic [W-1:0] ula_out,
  output logic         ula_flag
);

  typedef enum logic [3:0] {
    REG_HOLD = 4'd0,
    REG_LOAD = 4'd1,
    REG_SHR  = 4'd2,
    REG_SHL  = 4'd3,
    REG_CLR  = 4'd4
  } reg_op_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_MAIOR = 4'd2,
    ALU_MENOR = 4'd3,
    ALU_IGUAL = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_AND   = 4'd6
  } alu_op_e;

  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] z_q, z_d;
  logic         flag_q, flag_d;

  logic [W:0]   sum_w;
  logic [W:0]   diff_w;
  logic [W-1:0] alu_res;

  function automatic logic [W-1:0] reg_next(input logic [W-1:0] cur,
                                            input logic [W-1:0] src,
                                            input logic [3:0]   op);
    logic [W-1:0] r;
    r = cur;
    case (op)
      REG_LOAD: r = src;
      REG_SHR:  r = {1'b0, cur[W-1:1]};
      REG_SHL:  r = {cur[W-2:0], 1'b0};
      REG_CLR:  r = '0;
      default:  r = cur;
    endcase
    return r;
  endfunction

  // Extra MSB on sum/diff gives carry-out and borrow directly.
  always_comb begin
    sum_w   = {1'b0, x_q} + {1'b0, y_q};
    diff_w  = {1'b0, x_q} - {1'b0, y_q};
    alu_res = '0;
    case (Tula)
      ALU_ADD:   alu_res = sum_w[W-1:0];
      ALU_SUB:   alu_res = diff_w[W-1:0];
      ALU_MAIOR: alu_res = W'(x_q > y_q);
      ALU_MENOR: alu_res = W'(x_q < y_q);
      ALU_IGUAL: alu_res = W'(x_q == y_q);
      ALU_XOR:   alu_res = x_q ^ y_q;
      ALU_AND:   alu_res = x_q & y_q;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    x_d    = reg_next(x_q, entrada, Tx);
    y_d    = reg_next(y_q, alu_res, Ty);
    z_d    = reg_next(z_q, y_q, Tz);
    flag_d = flag_q;
    if (Ty == REG_LOAD) begin
      case (Tula)
        ALU_ADD: flag_d = sum_w[W];
        ALU_SUB: flag_d = diff_w[W];
        default: flag_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      flag_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      flag_q <= flag_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign z        = z_q;
  assign ula_out  = alu_res;
  assign ula_flag = flag_q;

endmodule

// File: tb/tb_datapath_xyz.sv
// Directed bench for datapath_xyz: stimulus pushes hand-computed post-edge state into a
// scoreboard queue; a negedge monitor pops and compares.
module tb_datapath_xyz;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] entrada;
  logic [3:0]   Tx, Ty, Tz, Tula;
  logic [W-1:0] x, y, z, ula_out;
  logic         ula_flag;

  typedef struct {
    string      name;
    logic [3:0] ex, ey, ez, eu;
    logic       ef;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  datapath_xyz #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .entrada  (entrada),
    .Tx       (Tx),
    .Ty       (Ty),
    .Tz       (Tz),
    .Tula     (Tula),
    .x        (x),
    .y        (y),
    .z        (z),
    .ula_out  (ula_out),
    .ula_flag (ula_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if ({x, y, z, ula_out, ula_flag} !== {e.ex, e.ey, e.ez, e.eu, e.ef}) begin
        bad++;
        $display("FAIL %s: got x=%0d y=%0d z=%0d ula=%0d flag=%0b, want x=%0d y=%0d z=%0d ula=%0d flag=%0b",
                 e.name, x, y, z, ula_out, ula_flag, e.ex, e.ey, e.ez, e.eu, e.ef);
      end
    end
  end

  // Drive one op set across one rising edge; expectation is the state seen after that edge
  // with the same inputs still applied (ula_out reflects the new x/y and current Tula).
  task automatic step(input string nm, input logic r, input logic [3:0] e,
                      input logic [3:0] tx, input logic [3:0] ty, input logic [3:0] tz,
                      input logic [3:0] tu,
                      input logic [3:0] ex, input logic [3:0] ey, input logic [3:0] ez,
                      input logic [3:0] eu, input logic ef);
    exp_t v;
    rst = r; entrada = e; Tx = tx; Ty = ty; Tz = tz; Tula = tu;
    v.name = nm; v.ex = ex; v.ey = ey; v.ez = ez; v.eu = eu; v.ef = ef;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; entrada = '0; Tx = '0; Ty = '0; Tz = '0; Tula = '0;
    //        name           rst e   Tx  Ty  Tz  Tula  x   y   z   ula f
    step("reset",         1, 0,  0,  0,  0,  0,    0,  0,  0,  0, 0);
    step("load_x5",       0, 5,  1,  0,  0,  0,    5,  0,  0,  5, 0);
    step("dec_e1",        0, 3,  1,  1,  0,  0,    3,  5,  0,  8, 0);
    step("dec_e2",        0, 3,  4,  1,  4,  0,    0,  8,  0,  8, 0);
    step("dec_e3",        0, 0,  0,  2,  0,  0,    0,  4,  0,  4, 0);
    step("dec_e4",        0, 0,  0,  0,  1,  0,    0,  4,  4,  4, 0);
    step("y_clr_x7",      0, 7,  1,  4,  0,  0,    7,  0,  4,  7, 0);
    step("y_ld7_x12",     0, 12, 1,  1,  0,  0,    12, 7,  4,  3, 0);
    step("carry",         0, 0,  0,  1,  0,  0,    12, 3,  4,  15, 1);
    step("x2_flag_hold",  0, 2,  1,  0,  0,  1,    2,  3,  4,  15, 1);
    step("borrow",        0, 0,  0,  1,  0,  1,    2,  15, 4,  3, 1);
    step("x9_yclr",       0, 9,  1,  4,  0,  0,    9,  0,  4,  9, 1);
    step("y9_x6",         0, 6,  1,  1,  0,  0,    6,  9,  4,  15, 0);
    step("alu_maior",     0, 0,  0,  0,  0,  2,    6,  9,  4,  0, 0);
    step("alu_menor",     0, 0,  0,  0,  0,  3,    6,  9,  4,  1, 0);
    step("alu_igual",     0, 0,  0,  0,  0,  4,    6,  9,  4,  0, 0);
    step("alu_xor",       0, 0,  0,  0,  0,  5,    6,  9,  4,  15, 0);
    step("alu_and",       0, 0,  0,  0,  0,  6,    6,  9,  4,  0, 0);
    step("alu_op9",       0, 0,  0,  0,  0,  9,    6,  9,  4,  0, 0);
    step("y_shl",         0, 0,  0,  3,  0,  0,    6,  2,  4,  8, 0);
    step("y_shr",         0, 0,  0,  2,  0,  0,    6,  1,  4,  7, 0);
    step("ty_illegal7",   0, 0,  0,  7,  0,  0,    6,  1,  4,  7, 0);
    step("tx_illegal12",  0, 15, 12, 0,  0,  0,    6,  1,  4,  7, 0);
    step("y_shr_to0",     0, 0,  0,  2,  0,  0,    6,  0,  4,  6, 0);
    step("y_shr_stay0",   0, 0,  0,  2,  0,  0,    6,  0,  4,  6, 0);
    step("z_clr_y6",      0, 0,  0,  1,  4,  0,    6,  6,  0,  12, 0);
    step("simul_update",  0, 0,  0,  4,  1,  0,    6,  0,  6,  6, 0);
    step("x3",            0, 3,  1,  0,  0,  0,    3,  0,  6,  3, 0);
    step("rst_priority",  1, 9,  1,  1,  1,  0,    0,  0,  0,  0, 0);
    step("x15",           0, 15, 1,  0,  0,  0,    15, 0,  0,  15, 0);
    step("y15",           0, 0,  0,  1,  0,  0,    15, 15, 0,  14, 0);
    step("carry2",        0, 0,  0,  1,  0,  0,    15, 14, 0,  13, 1);
    step("xor_clr_flag",  0, 0,  0,  1,  0,  5,    15, 1,  0,  14, 0);
    step("z_shl_src_y",   0, 0,  0,  0,  1,  5,    15, 1,  1,  14, 0);
    step("z_shl",         0, 0,  0,  0,  3,  5,    15, 1,  2,  14, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
